// File: rtl/shape_processor_bank_pkg.sv
// Shared types and legality rules for the shape processor control-register bank.
// Encodings, CTRL field layout and address-map helpers live here so channel and top agree.
package shape_processor_bank_pkg;

  typedef enum logic [2:0] {
    CIRCLE     = 3'd0,
    RECTANGLE  = 3'd1,
    TRIANGLE   = 3'd2,
    KEEP_SHAPE = 3'd7
  } shape_e;

  typedef enum logic [2:0] {
    PERIMETER      = 3'd0,
    AREA           = 3'd1,
    IS_SQUARE      = 3'd2,
    IS_EQUILATERAL = 3'd3,
    IS_ISOSCELES   = 3'd4,
    KEEP_OPERATION = 3'd7
  } operation_e;

  typedef struct packed {
    operation_e operation;
    shape_e     shape;
  } ctrl_sfr_reg;

  localparam int          CTRL_SHAPE_LSB = 0;
  localparam int          CTRL_OP_LSB    = 4;
  localparam ctrl_sfr_reg CTRL_RESET     = '{operation: PERIMETER, shape: CIRCLE};

  function automatic logic is_reserved_shape(input logic [2:0] s);
    return (s >= 3'd3) && (s <= 3'd6);
  endfunction

  function automatic logic is_reserved_operation(input logic [2:0] o);
    return (o >= 3'd5) && (o <= 3'd6);
  endfunction

  // Expects KEEP codes already resolved against the base register.
  function automatic logic is_legal_combination(input shape_e s, input operation_e o);
    logic legal;
    case (o)
      PERIMETER, AREA:              legal = (s == CIRCLE) || (s == RECTANGLE) || (s == TRIANGLE);
      IS_SQUARE:                    legal = (s == RECTANGLE);
      IS_EQUILATERAL, IS_ISOSCELES: legal = (s == TRIANGLE);
      default:                      legal = 1'b0;
    endcase
    return legal;
  endfunction

  function automatic int unsigned status_offset(input int unsigned num_channels);
    return num_channels;
  endfunction

  function automatic int unsigned commit_offset(input int unsigned num_channels);
    return num_channels + 1;
  endfunction

  function automatic logic [31:0] ctrl_to_word(input ctrl_sfr_reg r);
    return {25'd0, r.operation, 1'b0, r.shape};
  endfunction

endpackage

// File: rtl/shape_processor_channel_sfr.sv
// One channel of the bank: shadow/active CTRL registers, write legality check, sticky error bit.
// In direct mode the shadow tracks the active register, so it always equals it.
module shape_processor_channel_sfr
  import shape_processor_bank_pkg::*;
#(
  parameter bit SHADOWED = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_wr_en,
  input  logic [2:0]  i_shape,
  input  logic [2:0]  i_operation,
  input  logic        i_commit,
  input  logic        i_status_clr,
  output logic        o_reject,
  output logic        o_status,
  output ctrl_sfr_reg o_active,
  output logic        o_pending
);

  ctrl_sfr_reg r_active;
  ctrl_sfr_reg r_shadow;
  logic        r_status;

  ctrl_sfr_reg w_base;
  ctrl_sfr_reg w_next;
  shape_e      w_eff_shape;
  operation_e  w_eff_op;
  logic        w_accept;

  always_comb begin
    w_base      = SHADOWED ? r_shadow : r_active;
    w_eff_shape = (i_shape == KEEP_SHAPE)         ? w_base.shape     : shape_e'(i_shape);
    w_eff_op    = (i_operation == KEEP_OPERATION) ? w_base.operation : operation_e'(i_operation);
    w_next      = '{operation: w_eff_op, shape: w_eff_shape};
    o_reject    = i_wr_en && (is_reserved_shape(i_shape) ||
                              is_reserved_operation(i_operation) ||
                              !is_legal_combination(w_eff_shape, w_eff_op));
    w_accept    = i_wr_en && !o_reject;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= CTRL_RESET;
      r_shadow <= CTRL_RESET;
    end else if (w_accept) begin
      r_shadow <= w_next;
      if (!SHADOWED) begin
        r_active <= w_next;
      end
    end else if (SHADOWED && i_commit) begin
      r_active <= r_shadow;
    end
  end

  // A reject and a W1C cannot land together: both need the single bus write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_status <= 1'b0;
    end else if (o_reject) begin
      r_status <= 1'b1;
    end else if (i_status_clr) begin
      r_status <= 1'b0;
    end
  end

  assign o_status  = r_status;
  assign o_active  = r_active;
  assign o_pending = SHADOWED && (r_shadow != r_active);

endmodule

// File: rtl/shape_processor_ctrl_bank.sv
// Multi-channel SHAPE/OPERATION control bank: address decode, STATUS W1C, COMMIT fan-out, read mux.
// Map: 0..N-1 channel CTRL, N STATUS, N+1 COMMIT, everything above is unmapped.
module shape_processor_ctrl_bank
  import shape_processor_bank_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int SHADOWED     = 0,
  parameter int ADDR_W       = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      write,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [31:0]               write_data,
  input  logic                      read,
  output logic [31:0]               read_data,
  output logic                      error,
  output logic [3*NUM_CHANNELS-1:0] channel_shape,
  output logic [3*NUM_CHANNELS-1:0] channel_operation,
  output logic [NUM_CHANNELS-1:0]   pending
);

  localparam bit          LP_SHADOWED = (SHADOWED != 0);
  localparam int unsigned STATUS_ADDR = status_offset(NUM_CHANNELS);
  localparam int unsigned COMMIT_ADDR = commit_offset(NUM_CHANNELS);

  logic        w_is_ctrl;
  logic        w_is_status;
  logic        w_is_commit;
  logic        w_unmapped;
  logic        w_commit;
  logic [31:0] w_rdata;
  logic        w_unused_wdata;

  logic [NUM_CHANNELS-1:0] w_ch_wr;
  logic [NUM_CHANNELS-1:0] w_status_clr;
  logic [NUM_CHANNELS-1:0] w_reject;
  logic [NUM_CHANNELS-1:0] w_status;
  ctrl_sfr_reg             w_active [NUM_CHANNELS];

  logic [31:0] r_read_data;
  logic        r_error;

  always_comb begin
    w_is_ctrl   = (addr < ADDR_W'(NUM_CHANNELS));
    w_is_status = (addr == ADDR_W'(STATUS_ADDR));
    w_is_commit = (addr == ADDR_W'(COMMIT_ADDR));
    w_unmapped  = !(w_is_ctrl || w_is_status || w_is_commit);
    w_commit    = write && w_is_commit;
  end

  // Only the CTRL fields and the STATUS clear mask are meaningful payload bits.
  assign w_unused_wdata = ^write_data;

  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
    assign w_ch_wr[gi]      = write && (addr == ADDR_W'(gi));
    assign w_status_clr[gi] = write && w_is_status && write_data[gi];

    shape_processor_channel_sfr #(
      .SHADOWED (LP_SHADOWED)
    ) u_sfr (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_wr_en      (w_ch_wr[gi]),
      .i_shape      (write_data[CTRL_SHAPE_LSB +: 3]),
      .i_operation  (write_data[CTRL_OP_LSB +: 3]),
      .i_commit     (w_commit),
      .i_status_clr (w_status_clr[gi]),
      .o_reject     (w_reject[gi]),
      .o_status     (w_status[gi]),
      .o_active     (w_active[gi]),
      .o_pending    (pending[gi])
    );

    assign channel_shape[3*gi +: 3]     = w_active[gi].shape;
    assign channel_operation[3*gi +: 3] = w_active[gi].operation;
  end

  // Reads see the active registers before any same-cycle write lands.
  always_comb begin
    w_rdata = '0;
    if (w_is_ctrl) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (addr == ADDR_W'(i)) begin
          w_rdata = ctrl_to_word(w_active[i]);
        end
      end
    end else if (w_is_status) begin
      w_rdata[NUM_CHANNELS-1:0] = w_status;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_read_data <= '0;
      r_error     <= 1'b0;
    end else begin
      if (read) begin
        r_read_data <= w_rdata;
      end
      r_error <= (write && (w_unmapped || (|w_reject))) || (read && w_unmapped);
    end
  end

  assign read_data = r_read_data;
  assign error     = r_error;

endmodule

// File: doc/shape_processor_ctrl_bank.md
# shape_processor_ctrl_bank

Multi-channel control-register bank for the shape processor. It holds NUM_CHANNELS independent SHAPE/OPERATION control SFRs behind one address-decoded write/read bus. Each channel applies the legality rules of the single-channel CTRL SFR: reserved values rejected, KEEP codes, legal combinations only. New behaviour: a per-channel sticky error status, and an optional shadowed mode where writes are staged and made active together by a COMMIT write.

## Interface
Parameters:
- NUM_CHANNELS, 4, number of channel SFRs; legal range 1..16
- SHADOWED, 0, 1 = writes go to shadow registers and take effect on COMMIT; 0 = writes take effect directly
- ADDR_W, 5, word-address width; must satisfy 2^ADDR_W >= NUM_CHANNELS+2

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  reset; asynchronous, active-low
- write  in  1  write strobe, one-cycle qualifier
- addr  in  ADDR_W  word address for write or read
- write_data  in  32  write payload
- read  in  1  read strobe
- read_data  out  32  read return, registered
- error  out  1  one-cycle pulse flagging a rejected access
- channel_shape  out  3*NUM_CHANNELS  active SHAPE per channel, channel i at [3i+2:3i]
- channel_operation  out  3*NUM_CHANNELS  active OPERATION per channel
- pending  out  NUM_CHANNELS  shadow differs from active (always 0 when SHADOWED=0)

## Operation
- CTRL layout: SHAPE = write_data[2:0], OPERATION = write_data[6:4]; other bits ignored on write, read as 0.
- SHAPE: 0 CIRCLE, 1 RECTANGLE, 2 TRIANGLE, 3..6 reserved, 7 KEEP_SHAPE.
- OPERATION: 0 PERIMETER, 1 AREA, 2 IS_SQUARE, 3 IS_EQUILATERAL, 4 IS_ISOSCELES, 5..6 reserved, 7 KEEP_OPERATION.
- Legal combinations: PERIMETER/AREA with any shape; IS_SQUARE only with RECTANGLE; IS_EQUILATERAL/IS_ISOSCELES only with TRIANGLE.
- Address map: 0..N-1 = CTRL of channel addr; N = STATUS (bit i = sticky error of channel i, write-1-to-clear); N+1 = COMMIT (write-only, reads 0); anything else is unmapped.
- CTRL write check: a reserved SHAPE or OPERATION is rejected. A KEEP field is replaced by the base register's field before the combination check. The base register is the shadow if SHADOWED, else the active register.
- Legal write: each non-KEEP field is updated in the base register. Writing KEEP_SHAPE and KEEP_OPERATION together is legal and changes nothing.
- Rejected write: no register changes, error pulses, STATUS bit of that channel is set.
- Unmapped write or read: no state change, error pulses, STATUS unchanged, read_data = 0.
- COMMIT (SHADOWED=1): every channel's shadow is copied to its active register in the same edge; pending clears. With SHADOWED=0, COMMIT writes are ignored with no error.
- pending[i] = (shadow_i != active_i).
- A read of CTRL returns the active register, never the shadow.

## Timing
- Reset values: active and shadow = CIRCLE/PERIMETER, STATUS = 0, read_data = 0, error = 0, pending = 0. Reset mid-operation discards staged shadows immediately.
- Write: register update visible on outputs the cycle after the write strobe. error pulses in that same cycle.
- Read: read_data valid the cycle after read and holds until the next read.
- write and read in the same cycle: the read returns the pre-write value.
- STATUS W1C and a new error on the same bit cannot coincide, since the bus allows one write per cycle.
- COMMIT in the same cycle as reset deassertion is ignored.
- The active register never holds a reserved or illegal combination.

## Structure
- Package shape_processor_bank_pkg holds:
  - the shape_e and operation_e enums, including KEEP codes
  - the ctrl_sfr_reg packed struct
  - is_reserved_shape, is_reserved_operation and is_legal_combination
  - the STATUS/COMMIT offset functions of NUM_CHANNELS
- Sub-module shape_processor_channel_sfr, one instance per channel, holds the shadow and active registers, the legality check and the error set.
- The top level holds address decode, STATUS, COMMIT fan-out and the read mux.

## Test plan
- N=4, SHADOWED=0: write ch2 = 0x21 (TRIANGLE, IS_EQUILATERAL is 0x32) → write 0x32 → next cycle channel_shape[8:6]=2, channel_operation[8:6]=3, error=0.
- Write ch1 = 0x30 (CIRCLE + IS_EQUILATERAL) → error pulse, ch1 unchanged, STATUS read = 0x2. Write STATUS 0x2 → STATUS reads 0.
- ch0 = RECTANGLE/AREA, then write 0x27 (KEEP_SHAPE, IS_SQUARE) → ch0 = RECTANGLE/IS_SQUARE. Then write 0x72 (TRIANGLE, KEEP_OPERATION) → rejected, error pulses.
- SHADOWED=1: write ch0 = 0x11 and ch3 = 0x12 → actives unchanged, pending=0x9. COMMIT → both active on the next cycle, pending=0.
- Write shadow ch1, then assert rst_n=0 before COMMIT → all channels CIRCLE/PERIMETER, pending=0. Access addr 7 with N=4 → error pulse, read_data=0.
